// File: rtl/uart_frame_tx.sv
// Multi-byte UART transmitter: sends 1..MAX_BYTES bytes of a latched word, LSB byte first,
// as back-to-back 8N1/8E1/8O1 frames with one or two stop bits.
module uart_frame_tx #(
  parameter int unsigned TICK_DIV      = 54,
  parameter int unsigned TICKS_PER_BIT = 4,
  parameter int unsigned MAX_BYTES     = 4,
  parameter int unsigned CNT_W         = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop_tx,
  input  logic [CNT_W-1:0]       num_bytes,
  input  logic [8*MAX_BYTES-1:0] tx_data,
  input  logic                   parity_en,
  input  logic                   parity_odd,
  input  logic                   two_stop,
  output logic                   tx,
  output logic                   ready,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted,
  output logic [CNT_W-1:0]       byte_idx
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam logic [TW-1:0]    TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0]    SUB_MAX  = SW'(TICKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_BYTES);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state, state_n;
  logic [TW-1:0]          tick, tick_n;
  logic [SW-1:0]          sub, sub_n;
  logic [2:0]             bit_cnt, bit_cnt_n;
  logic [8*MAX_BYTES-1:0] word, word_n;
  logic [CNT_W-1:0]       n_bytes, n_bytes_n;
  logic                   par_en_q, par_en_n;
  logic                   par_odd_q, par_odd_n;
  logic                   two_stop_q, two_stop_n;
  logic                   tx_n, ready_n, busy_n, done_n, aborted_n;
  logic [CNT_W-1:0]       byte_idx_n;

  logic                   bit_end;
  logic                   more;
  logic [2:0]             nxt_bit;
  logic [7:0]             cur_byte;

  // The current byte always sits in the low 8 bits; the word shifts down per byte.
  assign cur_byte = word[7:0];
  assign more     = (byte_idx + CNT_W'(1)) < n_bytes;
  assign nxt_bit  = bit_cnt + 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tick       <= '0;
      sub        <= '0;
      bit_cnt    <= '0;
      word       <= '0;
      n_bytes    <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      two_stop_q <= 1'b0;
      tx         <= 1'b1;
      ready      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      byte_idx   <= '0;
    end else begin
      state      <= state_n;
      tick       <= tick_n;
      sub        <= sub_n;
      bit_cnt    <= bit_cnt_n;
      word       <= word_n;
      n_bytes    <= n_bytes_n;
      par_en_q   <= par_en_n;
      par_odd_q  <= par_odd_n;
      two_stop_q <= two_stop_n;
      tx         <= tx_n;
      ready      <= ready_n;
      busy       <= busy_n;
      done       <= done_n;
      aborted    <= aborted_n;
      byte_idx   <= byte_idx_n;
    end
  end

  always_comb begin
    state_n    = state;
    tick_n     = tick;
    sub_n      = sub;
    bit_cnt_n  = bit_cnt;
    word_n     = word;
    n_bytes_n  = n_bytes;
    par_en_n   = par_en_q;
    par_odd_n  = par_odd_q;
    two_stop_n = two_stop_q;
    tx_n       = tx;
    busy_n     = busy;
    byte_idx_n = byte_idx;
    done_n     = 1'b0;
    aborted_n  = 1'b0;
    bit_end    = 1'b0;

    // Free-running bit timer; the wrap edge is the bit boundary, so the output register
    // changes exactly every TICK_DIV*TICKS_PER_BIT clocks.
    if (state != IDLE) begin
      bit_end = (tick == '0) && (sub == '0);
      if (tick == '0) begin
        tick_n = TICK_MAX;
        sub_n  = (sub == '0) ? SUB_MAX : sub - SW'(1);
      end else begin
        tick_n = tick - TW'(1);
      end
    end

    case (state)
      IDLE: begin
        tx_n       = 1'b1;
        busy_n     = 1'b0;
        byte_idx_n = '0;
        tick_n     = '0;
        sub_n      = '0;
        if (start && ready && (num_bytes != '0) && (num_bytes <= MAX_CNT)) begin
          state_n    = START;
          tx_n       = 1'b0;
          busy_n     = 1'b1;
          tick_n     = TICK_MAX;
          sub_n      = SUB_MAX;
          word_n     = tx_data;
          n_bytes_n  = num_bytes;
          par_en_n   = parity_en;
          par_odd_n  = parity_odd;
          two_stop_n = two_stop;
        end
      end
      START: begin
        if (bit_end) begin
          state_n   = DATA;
          bit_cnt_n = '0;
          tx_n      = cur_byte[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt == 3'd7) begin
            bit_cnt_n = '0;
            if (par_en_q) begin
              state_n = PARITY;
              tx_n    = (^cur_byte) ^ par_odd_q;
            end else begin
              state_n = STOP;
              tx_n    = 1'b1;
            end
          end else begin
            bit_cnt_n = nxt_bit;
            tx_n      = cur_byte[nxt_bit];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_n   = STOP;
          bit_cnt_n = '0;
          tx_n      = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (two_stop_q && (bit_cnt == '0)) begin
            bit_cnt_n = 3'd1;
          end else if (more && !stop_tx) begin
            state_n    = START;
            tx_n       = 1'b0;
            byte_idx_n = byte_idx + CNT_W'(1);
            word_n     = word >> 8;
          end else begin
            state_n    = IDLE;
            tx_n       = 1'b1;
            busy_n     = 1'b0;
            byte_idx_n = '0;
            tick_n     = '0;
            sub_n      = '0;
            done_n     = 1'b1;
            aborted_n  = more;
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase

    ready_n = (state_n == IDLE) && !stop_tx;
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Scoreboard bench for uart_frame_tx: expected frames are queued at start and compared
// sample-by-sample against the serial line.
module tb_uart_frame_tx;

  localparam int unsigned TD      = 4;
  localparam int unsigned TPB     = 2;
  localparam int unsigned MB      = 4;
  localparam int unsigned CW      = 3;
  localparam int unsigned BIT_CLK = TD * TPB;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stop_tx;
  logic [CW-1:0] num_bytes;
  logic [8*MB-1:0] tx_data;
  logic          parity_en;
  logic          parity_odd;
  logic          two_stop;
  logic          tx;
  logic          ready;
  logic          busy;
  logic          done;
  logic          aborted;
  logic [CW-1:0] byte_idx;

  int unsigned errors = 0;
  int unsigned checks = 0;

  typedef struct {
    logic [7:0]    data;
    logic          par_en;
    logic          par_bit;
    logic          two_stop;
    logic [CW-1:0] idx;
  } frame_t;

  frame_t exp_q[$];

  always #5 clk = ~clk;

  uart_frame_tx #(
    .TICK_DIV(TD),
    .TICKS_PER_BIT(TPB),
    .MAX_BYTES(MB),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stop_tx(stop_tx),
    .num_bytes(num_bytes),
    .tx_data(tx_data),
    .parity_en(parity_en),
    .parity_odd(parity_odd),
    .two_stop(two_stop),
    .tx(tx),
    .ready(ready),
    .busy(busy),
    .done(done),
    .aborted(aborted),
    .byte_idx(byte_idx)
  );

  task automatic push_frames(input logic [8*MB-1:0] data, input int unsigned n,
                             input logic pe, input logic po, input logic ts);
    frame_t f;
    for (int unsigned k = 0; k < n; k++) begin
      f.data     = data[8*k +: 8];
      f.par_en   = pe;
      f.par_bit  = (^f.data) ^ po;
      f.two_stop = ts;
      f.idx      = CW'(k);
      exp_q.push_back(f);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_low(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Pops every queued frame and checks each bit holds for exactly BIT_CLK samples, then
  // checks the end-of-transmission strobe lands on the very next sample.
  task automatic receive(input string name, input logic exp_abort);
    bit          ok;
    frame_t      f;
    logic [11:0] seq;
    int unsigned nb;
    int unsigned bad;
    int unsigned ctl_bad;
    logic        got;
    wait_low(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s start_bit: tx=%b, required 0 within 50 cycles", name, tx);
      exp_q.delete();
      return;
    end
    while (exp_q.size() > 0) begin
      f       = exp_q.pop_front();
      seq     = '1;
      seq[0]  = 1'b0;
      seq[8:1] = f.data;
      nb      = 10;
      if (f.par_en) begin
        seq[9] = f.par_bit;
        nb     = 11;
      end
      if (f.two_stop) nb = nb + 1;
      ctl_bad = 0;
      for (int unsigned b = 0; b < nb; b++) begin
        bad = 0;
        got = seq[b];
        for (int unsigned s = 0; s < BIT_CLK; s++) begin
          if (tx !== seq[b]) begin
            bad++;
            got = tx;
          end
          if (busy !== 1'b1 || done !== 1'b0 || byte_idx !== f.idx) ctl_bad++;
          @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
          errors++;
          $display("FAIL %s byte%0d bit%0d: tx=%b on %0d of %0d samples, required %b",
                   name, f.idx, b, got, bad, BIT_CLK, seq[b]);
        end
      end
      checks++;
      if (ctl_bad != 0) begin
        errors++;
        $display("FAIL %s byte%0d ctl: %0d bad samples (busy=%b done=%b byte_idx=%0d), required busy=1 done=0 byte_idx=%0d",
                 name, f.idx, ctl_bad, busy, done, byte_idx, f.idx);
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || aborted !== exp_abort || byte_idx !== '0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL %s end: done=%b busy=%b aborted=%b byte_idx=%0d tx=%b, required done=1 busy=0 aborted=%b byte_idx=0 tx=1",
               name, done, busy, aborted, byte_idx, tx, exp_abort);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop_tx = 1'b0; num_bytes = '0; tx_data = '0;
    parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1)      begin errors++; $display("FAIL reset_tx: got %b, required 1", tx); end
    checks++; if (ready !== 1'b0)   begin errors++; $display("FAIL reset_ready: got %b, required 0", ready); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done: got %b, required 0", done); end
    checks++; if (aborted !== 1'b0) begin errors++; $display("FAIL reset_aborted: got %b, required 0", aborted); end
    checks++; if (byte_idx !== '0)  begin errors++; $display("FAIL reset_byte_idx: got %0d, required 0", byte_idx); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (ready !== 1'b1)   begin errors++; $display("FAIL ready_after_reset: got %b, required 1", ready); end
  endtask

  task automatic test_single();
    num_bytes = 3'd1; tx_data = 32'h0000_00A5;
    parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
    push_frames(tx_data, 1, 1'b0, 1'b0, 1'b0);
    pulse_start();
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_latency: tx=%b busy=%b, required tx=0 busy=1", tx, busy);
    end
    receive("single", 1'b0);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL single_done_width: done=%b tx=%b, required done=0 tx=1", done, tx);
    end
  endtask

  task automatic test_multi_even();
    num_bytes = 3'd3; tx_data = 32'h00C3_3C81;
    parity_en = 1'b1; parity_odd = 1'b0; two_stop = 1'b0;
    push_frames(tx_data, 3, 1'b1, 1'b0, 1'b0);
    pulse_start();
    tx_data = 32'hFFFF_FFFF; num_bytes = 3'd1; parity_en = 1'b0; parity_odd = 1'b1; two_stop = 1'b1;
    receive("multi_even", 1'b0);
  endtask

  task automatic test_odd_two_stop();
    num_bytes = 3'd2; tx_data = 32'h0000_55AA;
    parity_en = 1'b1; parity_odd = 1'b1; two_stop = 1'b1;
    push_frames(tx_data, 2, 1'b1, 1'b1, 1'b1);
    pulse_start();
    receive("odd_two_stop", 1'b0);
  endtask

  task automatic test_abort();
    int unsigned bad;
    num_bytes = 3'd4; tx_data = 32'h4433_2211;
    parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
    push_frames(tx_data, 2, 1'b0, 1'b0, 1'b0);
    pulse_start();
    fork
      receive("abort", 1'b1);
      begin
        repeat (100) @(negedge clk);
        stop_tx = 1'b1;
      end
    join
    start = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1 || ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL abort_hold: %0d bad cycles (tx=%b ready=%b busy=%b done=%b), required tx=1 ready=0 busy=0 done=0",
               bad, tx, ready, busy, done);
    end
    start = 1'b0;
    stop_tx = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL abort_release_ready: got %b, required 1", ready); end
  endtask

  task automatic test_invalid();
    logic [CW-1:0] nbs [2];
    int unsigned bad;
    nbs[0] = 3'd0;
    nbs[1] = 3'd5;
    for (int i = 0; i < 2; i++) begin
      num_bytes = nbs[i]; tx_data = 32'h1234_5678;
      pulse_start();
      bad = 0;
      repeat (30) begin
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || ready !== 1'b1) bad++;
        @(negedge clk);
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL invalid_n%0d: %0d bad cycles (tx=%b busy=%b done=%b ready=%b), required tx=1 busy=0 done=0 ready=1",
                 nbs[i], bad, tx, busy, done, ready);
      end
    end
  endtask

  task automatic test_reset_mid();
    int unsigned bad;
    num_bytes = 3'd2; tx_data = 32'h0000_F00F;
    parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
    pulse_start();
    repeat (42) @(negedge clk);
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL reset_mid_pre: tx=%b, required 0 in data bit 4", tx); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || byte_idx !== '0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async: tx=%b busy=%b byte_idx=%0d done=%b, required tx=1 busy=0 byte_idx=0 done=0",
               tx, busy, byte_idx, done);
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_mid_quiet: %0d bad cycles (tx=%b busy=%b done=%b), required tx=1 busy=0 done=0",
               bad, tx, busy, done);
    end
    num_bytes = 3'd1; tx_data = 32'h0000_003C; parity_en = 1'b1; parity_odd = 1'b1;
    push_frames(tx_data, 1, 1'b1, 1'b1, 1'b0);
    pulse_start();
    receive("after_reset", 1'b0);
  endtask

  task automatic test_back_to_back();
    num_bytes = 3'd1; tx_data = 32'h0000_005A;
    parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
    push_frames(tx_data, 1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    receive("b2b_first", 1'b0);
    @(negedge clk);
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap: tx=%b busy=%b one cycle after done, required tx=0 busy=1", tx, busy);
    end
    start = 1'b0;
    push_frames(tx_data, 1, 1'b0, 1'b0, 1'b0);
    receive("b2b_second", 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_even();
    test_odd_two_stop();
    test_abort();
    test_invalid();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_frame_tx.md
Name: uart_frame_tx

Overview:
Parametrised multi-byte UART transmitter that replaces the fixed one/two-byte PMT count sender. It serialises 1..MAX_BYTES bytes of a latched word back-to-back, LSB byte first. Each byte is a full 8N1/8E1/8O1 frame with one or two stop bits. It sits between the PMT count/timebin logic and the board TX pin, with a software-visible stop request and a one-cycle done strobe for the count pipeline.

Parameters:
TICK_DIV, 54, clk cycles per baud sub-tick (50 MHz / (230400*4))
TICKS_PER_BIT, 4, sub-ticks per serial bit; bit period = TICK_DIV*TICKS_PER_BIT clocks
MAX_BYTES, 4, maximum bytes per transmission
CNT_W, 3, width of num_bytes and byte_idx (must hold MAX_BYTES)

Ports:
clk  in  1  master clock (single clock domain)
rst  in  1  reset, asynchronous, active-high
start  in  1  request transmission; sampled only when ready=1
stop_tx  in  1  level; blocks new starts and aborts after the current byte's stop bit(s)
num_bytes  in  CNT_W  bytes to send, latched on accept; valid range 1..MAX_BYTES
tx_data  in  8*MAX_BYTES  payload, latched on accept; byte k = tx_data[8k+7:8k]
parity_en  in  1  insert a parity bit after the data bits (latched on accept)
parity_odd  in  1  1 = odd parity, 0 = even parity (latched on accept)
two_stop  in  1  1 = two stop bits, 0 = one stop bit (latched on accept)
tx  out  1  serial line; idles high
ready  out  1  high in IDLE when stop_tx=0
busy  out  1  high from accept until return to IDLE
done  out  1  one-cycle pulse when all requested bytes have completed
aborted  out  1  one-cycle pulse, concurrent with done, if the transmission ended early due to stop_tx
byte_idx  out  CNT_W  index of the byte currently on the line; 0 in IDLE

Behaviour:
- Reset (async): tx=1, ready=0 while rst is high, busy=0, done=0, aborted=0, byte_idx=0, state=IDLE, dividers cleared. Reset mid-frame returns tx high immediately.
- All outputs are registered. ready=(state==IDLE)&&!stop_tx.
- Accept: start&&ready at edge N. If num_bytes==0 or num_bytes>MAX_BYTES, the request is ignored: stays IDLE, no done. Otherwise, at N+1: tx=0 (start bit), busy=1, byte_idx=0, and the divider is reloaded so the start bit lasts exactly one full bit period.
- Timing: the sub-tick divider counts TICK_DIV-1 down to 0. The bit counter counts TICKS_PER_BIT sub-ticks. Every bit (start, data, parity, stop) holds exactly TICK_DIV*TICKS_PER_BIT clocks with no jitter.
- States: IDLE -> START -> DATA (8 bits, LSB first) -> PARITY (only if parity_en) -> STOP (1 or 2 bit periods).
- Leaving STOP:
  - If byte_idx < num_bytes-1 and stop_tx=0: byte_idx++ and go to START. No idle gap between bytes.
  - Otherwise: go to IDLE and pulse done on the same cycle busy falls.
- Parity bit = XOR of the 8 data bits, inverted when parity_odd=1.
- stop_tx sampled at the end of STOP while more bytes remain: finish early, done=1 and aborted=1. stop_tx asserted during a byte never truncates that byte.
- Inputs are ignored while busy. Changes to tx_data, num_bytes or the mode bits during transmission have no effect.
- A start held high continuously causes back-to-back transmissions. A new accept is possible on the cycle after done, giving one IDLE cycle of tx=1 on top of the stop bit(s).
- Frame length in clocks = num_bytes*(10+parity_en+two_stop)*TICK_DIV*TICKS_PER_BIT.

Test Plan:
1. TICK_DIV=4, TICKS_PER_BIT=2 (bit=8 clk), num_bytes=1, tx_data[7:0]=0xA5, 8N1, pulse start -> tx sequence 0,1,0,1,0,0,1,0,1,1 with each bit 8 clocks; done pulses exactly 80 clocks after tx first falls; busy low the same cycle.
2. num_bytes=3, tx_data=0x00C33C81, 8E1 -> bytes 0x81, 0x3C, 0xC3 sent in that order with parity bits 0,0,0; byte_idx steps 0,1,2; total duration 3*11*8=264 clocks; no idle gap between frames.
3. num_bytes=2, 0x55AA, odd parity, two_stop=1 -> parity bits 1,1; each stop period 16 clocks; done after 2*12*8=192 clocks.
4. num_bytes=4, assert stop_tx during the 2nd byte's data bits -> 2nd byte completes with full stop bit; then done=1 and aborted=1; tx stays high; ready stays 0 until stop_tx is released.
5. num_bytes=0 with start, then num_bytes=5 with start (MAX_BYTES=4) -> no transmission, busy/done never assert; tx=1 throughout.
6. Assert rst for 1 cycle mid data bit 4 of a 2-byte send -> tx=1, busy=0, byte_idx=0 immediately with no done pulse; a following start produces a clean full frame.
